// File: rtl/instruction_fetch.sv
// Purpose : RISC-V fetch stage; owns the PC, reads the combinational imem, fills one fetch/decode slot.
// Latency : one cycle from imem_addr_o=p to the word at p sitting valid in the slot; one bubble per redirect.
// Backpres: the slot and PC hold while if_valid_o=1 and if_ready_i=0; redirects are never blocked by backpressure.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   imem_addr_o / imem_instr_i     byte address out (always the PC register), instruction word back same cycle
//   redirect_valid_i/redirect_pc_i taken branch/jump target from execute
//   if_valid_o/if_ready_i          slot handshake to decode; if_instr_o/if_pc_o are the slot contents
//   fault_o                        sticky misaligned-redirect fault; stage halted until reset
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        fault_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        fault_q, fault_d;
    logic        slot_free;

    // The slot can take a new word if it is empty or is being handed to decode on this edge.
    assign slot_free = !vld_q || if_ready_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vld_d     = vld_q;
        instr_d   = instr_q;
        slot_pc_d = slot_pc_q;
        fault_d   = fault_q;

        if (state_q == RUN) begin
            if (redirect_valid_i) begin
                // Redirect wins over fetch and stall. The slot data is left in place;
                // only the valid bit drops, decode ignores contents while invalid.
                pc_d  = redirect_pc_i;
                vld_d = 1'b0;
                if (redirect_pc_i[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
            end else if (slot_free) begin
                instr_d   = imem_instr_i;
                slot_pc_d = pc_q;
                vld_d     = 1'b1;
                pc_d      = pc_q + 32'd4;   // modulo 2^32, wraps silently
            end
        end
        // HALT: everything holds; only reset leaves.
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            vld_q     <= 1'b0;
            instr_q   <= 32'h0;
            slot_pc_q <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            vld_q     <= vld_d;
            instr_q   <= instr_d;
            slot_pc_q <= slot_pc_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign if_valid_o  = vld_q;
    assign if_instr_o  = instr_q;
    assign if_pc_o     = slot_pc_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose : self-checking bench for instruction_fetch; scoreboard of expected (pc, instr) slots.
// Latency : inputs change 1 time unit after the rising edge, outputs are sampled before the next edge.
// Backpres: if_ready_i is driven per scenario; every handshake seen by the monitor must match the queue head.
module tb_instruction_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        fault_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t exp_q[$];

    always #5 clk_i = ~clk_i;

    // Combinational instruction memory: two known words at 0 and 4, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0040_2103;
            32'h0000_0004: mem_word = 32'h0020_2423;
            default:       mem_word = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .fault_o          (fault_o)
    );

    // Inputs only move just after a rising edge, so a handshake seen here is the one the next edge takes.
    always @(negedge clk_i) begin
        if (rst_n_i && if_valid_o && if_ready_i) begin
            item_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL transfer_unexpected: got pc=%h instr=%h, none expected", if_pc_o, if_instr_o);
            end else begin
                e = exp_q.pop_front();
                if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
                    fails++;
                    $display("FAIL transfer: got pc=%h instr=%h, expected pc=%h instr=%h",
                             if_pc_o, if_instr_o, e.pc, e.instr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_slot(input logic [31:0] pc);
        item_t it;
        it.pc    = pc;
        it.instr = mem_word(pc);
        exp_q.push_back(it);
    endtask

    task automatic test_reset();
        tests++;
        if ({if_valid_o, fault_o} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: valid/fault=%b, expected 00", {if_valid_o, fault_o});
        end
        tests++;
        if (if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_slot: instr=%h pc=%h, expected 0/0", if_instr_o, if_pc_o);
        end
        tests++;
        if (imem_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h, expected 00000000", imem_addr_o);
        end
    endtask

    task automatic test_stream_stall();
        expect_slot(32'h0);
        expect_slot(32'h4);
        @(negedge clk_i);
        rst_n_i    = 1'b1;
        if_ready_i = 1'b1;
        step();
        tests++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0040_2103) begin
            fails++;
            $display("FAIL first_fetch: valid=%b pc=%h instr=%h, expected 1/0/00402103",
                     if_valid_o, if_pc_o, if_instr_o);
        end
        step();
        if_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4 || imem_addr_o !== 32'h8) begin
                fails++;
                $display("FAIL stall_hold: valid=%b pc=%h addr=%h, expected 1/4/8",
                         if_valid_o, if_pc_o, imem_addr_o);
            end
        end
        if_ready_i = 1'b1;
        step();
        tests++;
        if (if_pc_o !== 32'h8 || if_instr_o !== mem_word(32'h8)) begin
            fails++;
            $display("FAIL stall_release: pc=%h instr=%h, expected 8/%h", if_pc_o, if_instr_o, mem_word(32'h8));
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: %0d slots outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        expect_slot(32'h8);
        expect_slot(32'h40);
        expect_slot(32'h44);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h40;
        step();
        redirect_valid_i = 1'b0;
        tests++;
        if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin
            fails++;
            $display("FAIL redirect_bubble: valid=%b addr=%h, expected 0/40", if_valid_o, imem_addr_o);
        end
        step();
        tests++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin
            fails++;
            $display("FAIL redirect_target: valid=%b pc=%h, expected 1/40", if_valid_o, if_pc_o);
        end
        step();
        step();
        if_ready_i = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL redirect_drain: %0d slots outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h80;
        step();
        redirect_pc_i    = 32'h100;
        step();
        redirect_valid_i = 1'b0;
        tests++;
        if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin
            fails++;
            $display("FAIL b2b_override: valid=%b addr=%h, expected 0/100", if_valid_o, imem_addr_o);
        end
        expect_slot(32'h100);
        if_ready_i = 1'b1;
        step();
        tests++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin
            fails++;
            $display("FAIL b2b_target: valid=%b pc=%h, expected 1/100", if_valid_o, if_pc_o);
        end
        step();
        if_ready_i = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: %0d slots outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFF8;
        step();
        redirect_valid_i = 1'b0;
        expect_slot(32'hFFFF_FFF8);
        expect_slot(32'hFFFF_FFFC);
        expect_slot(32'h0000_0000);
        if_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        if_ready_i = 1'b0;
        tests++;
        if (if_pc_o !== 32'h4 || imem_addr_o !== 32'h8) begin
            fails++;
            $display("FAIL wrap_pc: slot pc=%h addr=%h, expected 4/8", if_pc_o, imem_addr_o);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_drain: %0d slots outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_fault();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h42;
        step();
        redirect_valid_i = 1'b0;
        tests++;
        if (fault_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== 32'h42) begin
            fails++;
            $display("FAIL fault_entry: fault=%b valid=%b addr=%h, expected 1/0/42",
                     fault_o, if_valid_o, imem_addr_o);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        if_ready_i       = 1'b1;
        step();
        redirect_valid_i = 1'b0;
        step();
        tests++;
        if (fault_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== 32'h42) begin
            fails++;
            $display("FAIL fault_halt: fault=%b valid=%b addr=%h, expected 1/0/42",
                     fault_o, if_valid_o, imem_addr_o);
        end
        #3;
        rst_n_i = 1'b0;
        #1;
        tests++;
        if (fault_o !== 1'b0 || if_valid_o !== 1'b0 || imem_addr_o !== 32'h0 ||
            if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: fault=%b valid=%b addr=%h pc=%h instr=%h, expected all 0",
                     fault_o, if_valid_o, imem_addr_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_recover();
        expect_slot(32'h0);
        expect_slot(32'h4);
        @(negedge clk_i);
        rst_n_i    = 1'b1;
        if_ready_i = 1'b1;
        step();
        step();
        step();
        if_ready_i = 1'b0;
        tests++;
        if (fault_o !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL recover: fault=%b outstanding=%0d, expected 0/0", fault_o, exp_q.size());
        end
    endtask

    initial begin
        rst_n_i          = 1'b0;
        if_ready_i       = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        #12;
        test_reset();
        test_stream_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_fault();
        test_recover();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
